hazard_scheduler: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage RV32I core. It sits beside the decode stage and tracks a shadow scoreboard of the destination registers in flight in EX, MEM and WB. It drives the decode stage's forwarding selects, the bubble (`NOP`) and the pipeline-register enables. It also sequences load-use stalls, taken-jump flushes and memory-busy freezes, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_scheduler_if.sv | 45 ++++
 rtl/hazard_scheduler_sb_match.sv | 43 ++++
 rtl/hazard_scheduler.sv | 137 +++++++++++++
 tb/tb_hazard_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/forwarding controller:
//   - forward select encodings driven to the decode-stage operand muxes
//   - controller state encoding
//   - shadow scoreboard entry layout and a producer helper
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int RF_IDX_W = 5;

  // Operand source selects seen by the decode-stage bypass muxes.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } hz_state_e;

  // One in-flight destination: {valid_wr, is_load, rd}.
  typedef struct packed {
    logic                valid_wr;
    logic                is_load;
    logic [RF_IDX_W-1:0] rd;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  // x0 is hardwired to zero, so a write to it never produces a value.
  function automatic logic is_producer(sb_entry_t e);
    return e.valid_wr && (e.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// -----------------------------------------------------------------------------
// hazard_scheduler_if
// Decode-stage <-> hazard controller bundle.
//   master : decode side, drives ID instruction fields, jump_taken, mem_busy
//            and consumes enables, bubble/flush controls, forward selects and
//            performance counters.
//   slave  : the hazard controller.
// -----------------------------------------------------------------------------
interface hazard_scheduler_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Src1_hu;
  logic [4:0]       ID_Src2_hu;
  logic             id_use1;
  logic             id_use2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             jump_taken;
  logic             mem_busy;

  logic             pc_en;
  logic             IF_ID_en;
  logic             ID_EX_en;
  logic             IF_ID_flush;
  logic             NOP;
  logic [1:0]       forwardSrc1;
  logic [1:0]       forwardSrc2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_Src1_hu, ID_Src2_hu, id_use1, id_use2, id_rd,
           id_reg_write, id_mem_read, jump_taken, mem_busy,
    input  pc_en, IF_ID_en, ID_EX_en, IF_ID_flush, NOP,
           forwardSrc1, forwardSrc2, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_Src1_hu, ID_Src2_hu, id_use1, id_use2, id_rd,
           id_reg_write, id_mem_read, jump_taken, mem_busy,
    output pc_en, IF_ID_en, ID_EX_en, IF_ID_flush, NOP,
           forwardSrc1, forwardSrc2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scheduler_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Compares one ID source register against the EX/MEM/WB scoreboard entries.
//   src_i, use_i        : source index and whether the instruction reads it
//   ex_i, mem_i, wb_i   : scoreboard entries, youngest first
//   sel_o               : prioritised forward select (EX > MEM > WB > RF)
//   load_hit_o          : the EX producer for this source is a load
// -----------------------------------------------------------------------------
module sb_match
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  input  sb_entry_t  wb_i,
  output logic [1:0] sel_o,
  output logic       load_hit_o
);

  logic live_src;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // A source of x0 always reads the constant zero from the RF.
  assign live_src = use_i && (src_i != '0);
  assign hit_ex   = live_src && is_producer(ex_i)  && (ex_i.rd  == src_i);
  assign hit_mem  = live_src && is_producer(mem_i) && (mem_i.rd == src_i);
  assign hit_wb   = live_src && is_producer(wb_i)  && (wb_i.rd  == src_i);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the if-chain can leave it unassigned and infer a latch.
    sel_o = FWD_RF;
    if (hit_ex)       sel_o = FWD_EX;
    else if (hit_mem) sel_o = FWD_MEM;
    else if (hit_wb)  sel_o = FWD_WB;
  end

  assign load_hit_o = hit_ex && ex_i.is_load;

endmodule

// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks the destinations in flight in EX/MEM/WB, drives the decode-stage
// forward selects, the ID/EX bubble, pipeline register enables and the IF/ID
// flush, and counts stall/flush cycles with saturating counters.
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous reset, active-low
//   hz   : slave side of hazard_scheduler_if (ID fields in, controls out)
// Priority of control decisions: mem_busy freeze > load-use stall >
// jump flush > normal flow. All controls are combinational; only the
// scoreboard, state and counters are registered.
// -----------------------------------------------------------------------------
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scheduler_if.slave   hz
);

  sb_entry_t        ex_q, mem_q, wb_q;
  sb_entry_t        ex_d;
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_hit1;
  logic load_hit2;
  logic lu_hazard;

  sb_match u_match_src1 (
    .src_i      (hz.ID_Src1_hu),
    .use_i      (hz.id_use1),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (hz.forwardSrc1),
    .load_hit_o (load_hit1)
  );

  sb_match u_match_src2 (
    .src_i      (hz.ID_Src2_hu),
    .use_i      (hz.id_use2),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (hz.forwardSrc2),
    .load_hit_o (load_hit2)
  );

  // A freeze masks the stall: the load stays in EX and is re-evaluated on
  // the first cycle after mem_busy drops, costing exactly one bubble then.
  assign lu_hazard = (load_hit1 || load_hit2) && !hz.mem_busy;

  // ---------------------------------------------------------------------------
  // Pipeline controls
  // ---------------------------------------------------------------------------
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.IF_ID_en    = 1'b1;
    hz.ID_EX_en    = 1'b1;
    hz.NOP         = 1'b0;
    hz.IF_ID_flush = 1'b0;
    if (hz.mem_busy) begin
      hz.pc_en    = 1'b0;
      hz.IF_ID_en = 1'b0;
      hz.ID_EX_en = 1'b0;
    end else if (lu_hazard) begin
      // Hold PC and IF/ID, push a bubble into EX. A jump resolved now used
      // a stale operand, so it is not honoured until the retry.
      hz.pc_en    = 1'b0;
      hz.IF_ID_en = 1'b0;
      hz.NOP      = 1'b1;
    end else begin
      hz.IF_ID_flush = hz.jump_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d.valid_wr = hz.id_reg_write && !hz.NOP;
    ex_d.is_load  = hz.id_mem_read  && !hz.NOP;
    ex_d.rd       = hz.id_rd;

    if (hz.mem_busy)     state_d = FREEZE;
    else if (lu_hazard)  state_d = LU_STALL;
    else                 state_d = RUN;

    stall_cnt_d = stall_cnt_q;
    if (lu_hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (hz.IF_ID_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the scoreboard is three flop entries, not a RAM, so it is
      // reset explicitly; stale valid bits would fake hazards after reset.
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let the shift WB<-MEM<-EX read the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (!hz.mem_busy) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // The bubble injected by a load-use stall sits in EX next cycle, so the
  // same load can never stall two cycles in a row.
  a_single_cycle_stall : assert property (
    @(posedge clk) disable iff (!rst) (state_q == LU_STALL) |-> !lu_hazard
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hazard_scheduler
// Self-checking bench for hazard_scheduler (CNT_W = 4 so saturation is
// reachable). A reference model of the in-flight destinations (a 3-deep
// list, youngest first) predicts every control output on each negedge;
// directed sequences add literal expectations for the documented scenarios.
// Inputs change 1 time unit after posedge; the model compares on negedge.
// -----------------------------------------------------------------------------
module tb_hazard_scheduler;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(CNT_W)) hz_bus ();

  hazard_scheduler #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    bit ld;
    int rd;
  } ent_t;

  ent_t m_pipe[3];   // [0]=EX, [1]=MEM, [2]=WB
  int   m_stall;
  int   m_flush;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{v: 0, ld: 0, rd: 0};
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Youngest in-flight writer of src wins; x0 and unused sources read the RF.
  function automatic int model_fwd(int src, bit use_src);
    if (!use_src || src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (m_pipe[i].v && m_pipe[i].rd == src) return i + 1;
    return 0;
  endfunction

  function automatic bit model_lu(int s1, bit u1, int s2, bit u2);
    if (!m_pipe[0].v || !m_pipe[0].ld || m_pipe[0].rd == 0) return 0;
    return (u1 && s1 == m_pipe[0].rd) || (u2 && s2 == m_pipe[0].rd);
  endfunction

  always @(negedge clk) begin
    bit busy, lu, jmp, exp_pc, exp_ifid, exp_idex, exp_nop, exp_flush;
    int f1, f2;
    if (!rst) model_reset();
    busy = hz_bus.mem_busy;
    jmp  = hz_bus.jump_taken;
    lu   = !busy && model_lu(hz_bus.ID_Src1_hu, hz_bus.id_use1,
                             hz_bus.ID_Src2_hu, hz_bus.id_use2);
    exp_pc    = !busy && !lu;
    exp_ifid  = !busy && !lu;
    exp_idex  = !busy;
    exp_nop   = lu;
    exp_flush = !busy && !lu && jmp;
    f1 = model_fwd(hz_bus.ID_Src1_hu, hz_bus.id_use1);
    f2 = model_fwd(hz_bus.ID_Src2_hu, hz_bus.id_use2);

    check("m_pc_en",    hz_bus.pc_en,       exp_pc);
    check("m_if_id_en", hz_bus.IF_ID_en,    exp_ifid);
    check("m_id_ex_en", hz_bus.ID_EX_en,    exp_idex);
    check("m_nop",      hz_bus.NOP,         exp_nop);
    check("m_flush",    hz_bus.IF_ID_flush, exp_flush);
    check("m_fwd1",     hz_bus.forwardSrc1, f1);
    check("m_fwd2",     hz_bus.forwardSrc2, f2);
    check("m_stall_cnt", hz_bus.stall_cnt,  m_stall);
    check("m_flush_cnt", hz_bus.flush_cnt,  m_flush);

    // Apply the upcoming rising edge to the model.
    if (rst && !busy) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = '{v: hz_bus.id_reg_write && !lu, ld: hz_bus.id_mem_read && !lu,
                    rd: int'(hz_bus.id_rd)};
      if (lu && m_stall < CNT_MAX) m_stall++;
      if (exp_flush && m_flush < CNT_MAX) m_flush++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic jmp, input logic busy);
    hz_bus.ID_Src1_hu   = s1;
    hz_bus.id_use1      = u1;
    hz_bus.ID_Src2_hu   = s2;
    hz_bus.id_use2      = u2;
    hz_bus.id_rd        = rd;
    hz_bus.id_reg_write = rw;
    hz_bus.id_mem_read  = mr;
    hz_bus.jump_taken   = jmp;
    hz_bus.mem_busy     = busy;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input string tag, input logic pc, input logic ifid,
                            input logic idex, input logic nop, input logic fl);
    check({tag, "_pc_en"},    hz_bus.pc_en,       pc);
    check({tag, "_if_id_en"}, hz_bus.IF_ID_en,    ifid);
    check({tag, "_id_ex_en"}, hz_bus.ID_EX_en,    idex);
    check({tag, "_nop"},      hz_bus.NOP,         nop);
    check({tag, "_flush"},    hz_bus.IF_ID_flush, fl);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    #2;
    expect_ctl("reset", 1, 1, 1, 0, 0);
    check("reset_fwd1", hz_bus.forwardSrc1, 0);
    check("reset_fwd2", hz_bus.forwardSrc2, 0);
    check("reset_stall_cnt", hz_bus.stall_cnt, 0);
    check("reset_flush_cnt", hz_bus.flush_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // lw x5 ; add x6,x5,x1 -> one bubble, then forward from MEM.
    drive(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); #1;
    expect_ctl("lw", 1, 1, 1, 0, 0);
    step();
    drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); #1;
    expect_ctl("lu", 0, 0, 1, 1, 0);
    step();
    drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); #1;
    expect_ctl("lu_retry", 1, 1, 1, 0, 0);
    check("lu_retry_fwd1", hz_bus.forwardSrc1, 2);
    check("lu_retry_fwd2", hz_bus.forwardSrc2, 0);
    check("lu_stall_cnt", hz_bus.stall_cnt, 1);
    step();

    // addi x3 ; add x7,x3,x3 ; use x3 ; use x3 -> selects 1, 2, 3.
    drive(5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0); #1;
    check("addi_fwd1", hz_bus.forwardSrc1, 0);
    step();
    drive(5'd3, 1, 5'd3, 1, 5'd7, 1, 0, 0, 0); #1;
    expect_ctl("alu_dep", 1, 1, 1, 0, 0);
    check("alu_dep_fwd1", hz_bus.forwardSrc1, 1);
    check("alu_dep_fwd2", hz_bus.forwardSrc2, 1);
    step();
    drive(5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0, 0); #1;
    check("mem_dep_fwd1", hz_bus.forwardSrc1, 2);
    check("mem_dep_fwd2", hz_bus.forwardSrc2, 2);
    step();
    drive(5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, 0); #1;
    check("wb_dep_fwd1", hz_bus.forwardSrc1, 3);
    check("wb_dep_fwd2", hz_bus.forwardSrc2, 3);
    step();

    // Load into x0 followed by a reader of x0: nothing to stall or forward.
    drive(5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);
    step();
    drive(5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0); #1;
    expect_ctl("x0_reader", 1, 1, 1, 0, 0);
    check("x0_fwd1", hz_bus.forwardSrc1, 0);
    step();

    // Taken beq: flush for one cycle.
    drive(5'd9, 1, 5'd10, 1, 5'd0, 0, 0, 1, 0); #1;
    expect_ctl("beq", 1, 1, 1, 0, 1);
    step();
    idle(); #1;
    check("beq_flush_cnt", hz_bus.flush_cnt, 1);
    check("beq_after_flush", hz_bus.IF_ID_flush, 0);

    // lw x11 ; beq on x11 taken -> stall first, flush on the retry.
    drive(5'd1, 1, 5'd0, 0, 5'd11, 1, 1, 0, 0);
    step();
    drive(5'd11, 1, 5'd0, 1, 5'd0, 0, 0, 1, 0); #1;
    expect_ctl("beq_lu", 0, 0, 1, 1, 0);
    step();
    drive(5'd11, 1, 5'd0, 1, 5'd0, 0, 0, 1, 0); #1;
    expect_ctl("beq_retry", 1, 1, 1, 0, 1);
    check("beq_retry_fwd1", hz_bus.forwardSrc1, 2);
    step();
    idle(); #1;
    check("beq_lu_flush_cnt", hz_bus.flush_cnt, 2);
    check("beq_lu_stall_cnt", hz_bus.stall_cnt, 2);

    // lw x12 ; dependent held by 3 mem_busy cycles -> then one stall.
    drive(5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 1); #1;
      expect_ctl("freeze", 0, 0, 0, 0, 0);
      check("freeze_fwd1", hz_bus.forwardSrc1, 1);
      check("freeze_stall_cnt", hz_bus.stall_cnt, 2);
      step();
    end
    drive(5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 0); #1;
    expect_ctl("post_freeze_lu", 0, 0, 1, 1, 0);
    step();
    drive(5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 0); #1;
    expect_ctl("post_freeze_retry", 1, 1, 1, 0, 0);
    check("post_freeze_fwd1", hz_bus.forwardSrc1, 2);
    check("post_freeze_stall_cnt", hz_bus.stall_cnt, 3);
    step();

    // Randomised traffic with a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      logic rw;
      rw = ($urandom_range(3, 0) != 0);
      drive(5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            5'($urandom_range(7, 0)), rw, rw && ($urandom_range(2, 0) == 0),
            ($urandom_range(7, 0) == 0), ($urandom_range(5, 0) == 0));
      step();
    end

    // Fresh counters, then a long run of load-use pairs to saturate.
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int n = 0; n < CNT_MAX + 5; n++) begin
      drive(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
      step();
      drive(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
      step();
    end
    idle(); #1;
    check("sat_stall_cnt", hz_bus.stall_cnt, CNT_MAX);
    step();

    // Reset asserted in the middle of a load-use stall.
    drive(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    step();
    drive(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0); #1;
    check("pre_rst_nop", hz_bus.NOP, 1);
    rst = 1'b0;
    #1;
    expect_ctl("mid_rst", 1, 1, 1, 0, 0);
    check("mid_rst_fwd1", hz_bus.forwardSrc1, 0);
    check("mid_rst_stall_cnt", hz_bus.stall_cnt, 0);
    check("mid_rst_flush_cnt", hz_bus.flush_cnt, 0);
    step();
    idle();
    step();
    rst = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
